// File: rtl/glb_multibank.sv
// -----------------------------------------------------------------------------
// glb_multibank
//   Global buffer made of NUM_BANKS independent single-port synchronous banks.
//   One request per cycle selects one bank and either reads an entry, writes
//   an entry, or (optionally) accumulates an addend into an entry.
//
//   Read latency is two cycles: the bank registers its read word on the
//   acceptance edge, then the output stage registers it into o_rd.
//   A plain write lands at the end of the acceptance cycle, so a read of the
//   same entry one cycle later already sees the new word.
//
//   Compile-time option:
//     GLB_ACC_EN  defined   : i_we=1 with i_acc=1 runs a read-add-write sequence
//                             (IDLE -> ACC_RD -> ACC_WAIT -> ACC_WR -> IDLE),
//                             o_req_ready is low while it runs.
//     GLB_ACC_EN  undefined : i_acc is ignored, every write is a plain write,
//                             o_req_ready is always 1.
//
// Parameters
//   NUM_BANKS   number of banks (1..16)
//   BANK_WIDTH  data width of every bank
//   BANK_DEPTH  entries per bank (>= 2)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset (control and output stage only;
//                memory contents are never touched)
//   i_req_valid  request present
//   o_req_ready  request accepted when high together with i_req_valid
//   i_bank_sel   target bank
//   i_we         1 = write, 0 = read
//   i_acc        with i_we=1: accumulate instead of overwrite
//   i_addr       entry address
//   i_wd         write data / addend
//   o_rd_valid   one-cycle pulse, o_rd carries read data
//   o_rd         read data, holds between pulses
//   o_rd_bank    bank the o_rd data came from
//   o_err        one-cycle pulse: accepted request targeted a missing bank
// -----------------------------------------------------------------------------
module glb_multibank #(
  parameter  int NUM_BANKS  = 4,
  parameter  int BANK_WIDTH = 32,
  parameter  int BANK_DEPTH = 8192,
  localparam int AW         = $clog2(BANK_DEPTH),
  localparam int BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [BW-1:0]         i_bank_sel,
  input  logic                  i_we,
  input  logic                  i_acc,
  input  logic [AW-1:0]         i_addr,
  input  logic [BANK_WIDTH-1:0] i_wd,
  output logic                  o_rd_valid,
  output logic [BANK_WIDTH-1:0] o_rd,
  output logic [BW-1:0]         o_rd_bank,
  output logic                  o_err
);

  // Bank slots are padded to a power of two so any i_bank_sel value indexes
  // a defined read word; padding slots read as zero and are never accessed.
  localparam int          NSLOT  = 1 << BW;
  localparam logic [BW:0] NB_EXT = (BW + 1)'(NUM_BANKS);

  // Sum modulo 2^BANK_WIDTH (carry out is discarded on purpose).
  function automatic logic [BANK_WIDTH-1:0] wrap_add(
    input logic [BANK_WIDTH-1:0] a,
    input logic [BANK_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  logic                  in_range;
  logic                  accept;

  // Single shared access command; exactly one bank decodes it per cycle.
  logic                  mem_req;
  logic                  mem_wr;
  logic [BW-1:0]         mem_bank;
  logic [AW-1:0]         mem_addr;
  logic [BANK_WIDTH-1:0] mem_wd;

  logic [BANK_WIDTH-1:0] bank_rd [NSLOT];

  logic                  vld_p0;
  logic [BW-1:0]         bank_p0;

  // Compare with one extra bit so NUM_BANKS == 2**BW does not wrap to zero.
  assign in_range = ({1'b0, i_bank_sel} < NB_EXT);
  assign accept   = i_req_valid & o_req_ready & ~i_rst;

`ifdef GLB_ACC_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WAIT = 2'd2,
    ACC_WR   = 2'd3
  } state_t;

  state_t                state;
  logic                  ready_q;
  logic [BW-1:0]         acc_bank;
  logic [AW-1:0]         acc_addr;
  logic [BANK_WIDTH-1:0] acc_wd;
  logic [BANK_WIDTH-1:0] acc_sum;

  assign o_req_ready = ready_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // Out-of-range accumulates only raise o_err and never start the FSM.
          if (accept && in_range && i_we && i_acc) begin
            state   <= ACC_RD;
            ready_q <= 1'b0;
          end
        end
        ACC_RD:   state <= ACC_WAIT;
        ACC_WAIT: state <= ACC_WR;
        ACC_WR: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Operand capture; data path only, no reset needed.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      acc_bank <= i_bank_sel;
      acc_addr <= i_addr;
      acc_wd   <= i_wd;
    end
    // Bank read word issued in ACC_RD is valid here.
    if (state == ACC_WAIT) begin
      acc_sum <= wrap_add(bank_rd[acc_bank], acc_wd);
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_wr   = 1'b0;
    mem_bank = i_bank_sel;
    mem_addr = i_addr;
    mem_wd   = i_wd;
    case (state)
      IDLE: begin
        mem_req = accept & in_range & ~(i_we & i_acc);
        mem_wr  = i_we;
      end
      ACC_RD: begin
        mem_req  = ~i_rst;
        mem_bank = acc_bank;
        mem_addr = acc_addr;
      end
      ACC_WR: begin
        // Reset during the write-back cycle drops the write.
        mem_req  = ~i_rst;
        mem_wr   = 1'b1;
        mem_bank = acc_bank;
        mem_addr = acc_addr;
        mem_wd   = acc_sum;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end
`else
  logic unused_acc;

  assign unused_acc  = i_acc;
  assign o_req_ready = 1'b1;

  always_comb begin
    mem_req  = accept & in_range;
    mem_wr   = i_we;
    mem_bank = i_bank_sel;
    mem_addr = i_addr;
    mem_wd   = i_wd;
  end
`endif

  // Stage p0: bank array access (write, or registered read word per bank)
  for (genvar b = 0; b < NSLOT; b++) begin : g_bank
    if (b < NUM_BANKS) begin : g_mem
      logic [BANK_WIDTH-1:0] mem [BANK_DEPTH];
      logic [BANK_WIDTH-1:0] rd_p0;
      logic                  sel;

      assign sel = mem_req && (mem_bank == BW'(b));

      always_ff @(posedge i_clk) begin
        if (sel) begin
          if (mem_wr) begin
            mem[mem_addr] <= mem_wd;
          end else begin
            rd_p0 <= mem[mem_addr];
          end
        end
      end

      assign bank_rd[b] = rd_p0;
    end else begin : g_pad
      assign bank_rd[b] = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0  <= 1'b0;
      bank_p0 <= '0;
    end else begin
      vld_p0  <= accept & in_range & ~i_we;
      bank_p0 <= i_bank_sel;
    end
  end

  // Stage p1: output register; o_rd holds between valid pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_valid <= 1'b0;
      o_rd       <= '0;
      o_rd_bank  <= '0;
      o_err      <= 1'b0;
    end else begin
      o_rd_valid <= vld_p0;
      o_err      <= accept & ~in_range;
      if (vld_p0) begin
        o_rd      <= bank_rd[bank_p0];
        o_rd_bank <= bank_p0;
      end
    end
  end

endmodule

// File: tb/tb_glb_multibank.sv
// -----------------------------------------------------------------------------
// tb_glb_multibank
//   Drives two glb_multibank instances from the same request stream: one with
//   four banks and one with three banks, so bank index 3 is a valid bank on the
//   first and an out-of-range select on the second. Expected responses are
//   pushed into queues when a request is issued and popped by a monitor that
//   samples on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_glb_multibank;

  localparam int DEPTH = 16;
`ifdef GLB_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  bank_sel = '0;
  logic        we = 1'b0;
  logic        acc = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wd = '0;

  logic        ready4, rd_valid4, err4;
  logic [31:0] rd4;
  logic [1:0]  rd_bank4;
  logic        ready3, rd_valid3, err3;
  logic [31:0] rd3;
  logic [1:0]  rd_bank3;

  glb_multibank #(.NUM_BANKS(4), .BANK_WIDTH(32), .BANK_DEPTH(DEPTH)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready4),
    .i_bank_sel(bank_sel), .i_we(we), .i_acc(acc), .i_addr(addr), .i_wd(wd),
    .o_rd_valid(rd_valid4), .o_rd(rd4), .o_rd_bank(rd_bank4), .o_err(err4)
  );

  glb_multibank #(.NUM_BANKS(3), .BANK_WIDTH(32), .BANK_DEPTH(DEPTH)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready3),
    .i_bank_sel(bank_sel), .i_we(we), .i_acc(acc), .i_addr(addr), .i_wd(wd),
    .o_rd_valid(rd_valid3), .o_rd(rd3), .o_rd_bank(rd_bank3), .o_err(err3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  b;
    int          c;
  } exp_t;

  exp_t        q4[$];
  exp_t        q3[$];
  int          err_q3[$];
  logic [31:0] mdl [4][DEPTH];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last4 = '0;
  logic [31:0] last3 = '0;
  bit          mon_en = 1'b0;
  bit          prev_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_rd(input int w, input logic v, input logic [31:0] d, input logic [1:0] b);
    exp_t e;
    int   qs;
    qs = (w == 0) ? q4.size() : q3.size();
    if (v) begin
      if (qs == 0) begin
        checks++;
        errors++;
        $display("FAIL rd%0d_unexpected: o_rd_valid with data 0x%08h bank %0d, none expected (cycle %0d)",
                 w, d, b, cyc);
      end else begin
        if (w == 0) e = q4.pop_front();
        else        e = q3.pop_front();
        chk($sformatf("rd%0d_data", w), d, e.d);
        chk($sformatf("rd%0d_bank", w), {30'd0, b}, {30'd0, e.b});
        chk($sformatf("rd%0d_cycle", w), cyc, e.c);
        if (w == 0) last4 = e.d;
        else        last3 = e.d;
      end
    end else begin
      chk($sformatf("rd%0d_hold", w), d, (w == 0) ? last4 : last3);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp3;
      mon_rd(0, rd_valid4, rd4, rd_bank4);
      mon_rd(1, rd_valid3, rd3, rd_bank3);
      chk("err4", {31'd0, err4}, 32'd0);
      exp3 = (err_q3.size() > 0) && (err_q3[0] == cyc);
      if (exp3) void'(err_q3.pop_front());
      chk("err3", {31'd0, err3}, {31'd0, exp3});
      if (rst) begin
        last4 = '0;
        last3 = '0;
      end
    end
  end

  // Issue one request; the model and the expectation queues are updated here.
  task automatic issue(input logic [1:0] sel, input bit w, input bit a,
                       input logic [3:0] ad, input logic [31:0] d, input bit apply);
    int   waits;
    exp_t e;
    waits = 0;
    @(posedge clk); #1;
    while (!ready4 && waits < 8) begin
      waits++;
      @(posedge clk); #1;
    end
    if (prev_acc) chk("ready_low_cycles", waits, ACC_EN ? 32'd3 : 32'd0);
    else if (waits != 0) chk("ready_low_unexpected", waits, 32'd0);
    req_valid = 1'b1;
    bank_sel  = sel;
    we        = w;
    acc       = a;
    addr      = ad;
    wd        = d;
    prev_acc  = w && a;
    if (!w) begin
      e.d = mdl[sel][ad];
      e.b = sel;
      e.c = cyc + 2;
      q4.push_back(e);
      if (sel < 2'd3) q3.push_back(e);
      else            err_q3.push_back(cyc + 1);
    end else begin
      if (sel == 2'd3) err_q3.push_back(cyc + 1);
      if (apply) begin
        if (a && ACC_EN) mdl[sel][ad] = mdl[sel][ad] + d;
        else             mdl[sel][ad] = d;
      end
    end
  endtask

  // No request; the other inputs carry junk that must be ignored.
  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    bank_sel  = 2'($urandom_range(0, 3));
    we        = 1'($urandom_range(0, 1));
    acc       = 1'($urandom_range(0, 1));
    addr      = 4'($urandom_range(0, 15));
    wd        = $urandom;
    prev_acc  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready4", {31'd0, ready4}, 32'd1);
    chk("rst_ready3", {31'd0, ready3}, 32'd1);
    chk("rst_valid4", {31'd0, rd_valid4}, 32'd0);
    chk("rst_rd4", rd4, 32'd0);
    chk("rst_rd_bank4", {30'd0, rd_bank4}, 32'd0);
    chk("rst_err3", {31'd0, err3}, 32'd0);
    mon_en = 1'b1;

    // Preload every entry (bank 3 writes are out of range on the 3-bank part).
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < DEPTH; a++)
        issue(2'(b), 1'b1, 1'b0, 4'(a), $urandom, 1'b1);

    // Write then read of the same entry on the next cycle.
    issue(2'd2, 1'b1, 1'b0, 4'd5, 32'hDEADBEEF, 1'b1);
    issue(2'd2, 1'b0, 1'b0, 4'd5, 32'd0, 1'b1);

    // Back-to-back reads across all banks.
    for (int b = 0; b < 4; b++) issue(2'(b), 1'b1, 1'b0, 4'd0, 32'h10 + b, 1'b1);
    for (int b = 0; b < 4; b++) issue(2'(b), 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);

    // Wrap-around accumulate, then read back.
    issue(2'd0, 1'b1, 1'b0, 4'd9, 32'hFFFFFFFF, 1'b1);
    issue(2'd0, 1'b1, 1'b1, 4'd9, 32'd2, 1'b1);
    issue(2'd0, 1'b0, 1'b0, 4'd9, 32'd0, 1'b1);

    // Accumulate-flagged write of 7 over 5; a read issued just before it
    // must still deliver on time.
    issue(2'd2, 1'b1, 1'b0, 4'd4, 32'd5, 1'b1);
    issue(2'd2, 1'b0, 1'b0, 4'd4, 32'd0, 1'b1);
    issue(2'd2, 1'b1, 1'b1, 4'd4, 32'd7, 1'b1);
    issue(2'd2, 1'b0, 1'b0, 4'd4, 32'd0, 1'b1);

    // Reset two cycles after an accumulate is accepted (ACC_WAIT when enabled).
    repeat (4) idle();
    issue(2'd1, 1'b1, 1'b0, 4'd7, 32'h00000055, 1'b1);
    issue(2'd1, 1'b1, 1'b1, 4'd7, 32'h00000100, !ACC_EN);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    prev_acc = 1'b0;
    chk("midrst_ready4", {31'd0, ready4}, 32'd1);
    chk("midrst_ready3", {31'd0, ready3}, 32'd1);
    chk("midrst_valid4", {31'd0, rd_valid4}, 32'd0);
    chk("midrst_rd4", rd4, 32'd0);
    chk("midrst_rd_bank4", {30'd0, rd_bank4}, 32'd0);
    issue(2'd1, 1'b0, 1'b0, 4'd7, 32'd0, 1'b1);

    // Randomized traffic; accumulates stay on banks present in both parts.
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)
        issue(2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), $urandom, 1'b1);
      else if (r < 75)
        issue(2'($urandom_range(0, 3)), 1'b1, 1'b0, 4'($urandom_range(0, 15)), $urandom, 1'b1);
      else if (r < 88)
        issue(2'($urandom_range(0, 2)), 1'b1, 1'b1, 4'($urandom_range(0, 15)),
              32'($urandom_range(0, 1000)) - 32'd500, 1'b1);
      else
        idle();
    end

    // Final readback of every entry.
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < DEPTH; a++)
        issue(2'(b), 1'b0, 1'b0, 4'(a), 32'd0, 1'b1);

    repeat (6) idle();
    chk("drain_q4", q4.size(), 32'd0);
    chk("drain_q3", q3.size(), 32'd0);
    chk("drain_err3", err_q3.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/glb_multibank.md
GLB_MULTIBANK -- requirements
Module: glb_multibank

Interface
REQ-001 SHALL: NUM_BANKS, default 4, number of independent banks (1..16).
REQ-002 SHALL: BANK_WIDTH, default 32, data width of every bank in bits.
REQ-003 SHALL: BANK_DEPTH, default 8192, entries per bank; AW = ceil(log2(BANK_DEPTH)), BW = max(1, ceil(log2(NUM_BANKS))).
REQ-004 SHALL: i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL: i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL: i_req_valid  input  1  request present.
REQ-007 SHALL: o_req_ready  output  1  request accepted this cycle when high with i_req_valid.
REQ-008 SHALL: i_bank_sel  input  BW  target bank index.
REQ-009 SHALL: i_we  input  1  1 = write, 0 = read.
REQ-010 SHALL: i_acc  input  1  with i_we=1: accumulate instead of overwrite.
REQ-011 SHALL: i_addr  input  AW  entry address.
REQ-012 SHALL: i_wd  input  BANK_WIDTH  write data / addend.
REQ-013 SHALL: o_rd_valid  output  1  one-cycle pulse, o_rd holds read data.
REQ-014 SHALL: o_rd  output  BANK_WIDTH  read data.
REQ-015 SHALL: o_rd_bank  output  BW  bank index the o_rd data came from.
REQ-016 SHALL: o_err  output  1  one-cycle pulse: accepted request had i_bank_sel >= NUM_BANKS.

Function
REQ-017 SHALL: accept a request only on a cycle where i_req_valid and o_req_ready are both high; other inputs are ignored.
REQ-018 SHALL: each bank is a single-port synchronous memory; only the selected bank is read or written per request.
REQ-019 SHALL: read accepted in cycle T yields o_rd_valid=1 in cycle T+2, with o_rd = entry contents and o_rd_bank = bank of that request (bank index pipelined alongside address).
REQ-020 SHALL: sustain one read or plain write per cycle; o_req_ready stays 1 in IDLE.
REQ-021 SHALL: plain write accepted in T updates memory at end of T; a read of the same entry accepted in T+1 returns new data.
REQ-022 SHALL: o_rd holds its last value while o_rd_valid=0.
REQ-023 SHALL: out-of-range bank select: request accepted, no memory access, no o_rd_valid, o_err=1 in T+1.
REQ-024 SHALL: FSM states IDLE, ACC_RD, ACC_WAIT, ACC_WR; IDLE->ACC_RD on accepted accumulate; ACC_RD->ACC_WAIT->ACC_WR each one cycle; ACC_WR->IDLE.
REQ-025 SHALL: accumulate: read entry, add i_wd (latched at acceptance), sum modulo 2^BANK_WIDTH written back in ACC_WR; no o_rd_valid produced.
REQ-026 SHALL: o_req_ready=0 in ACC_RD, ACC_WAIT, ACC_WR; next request accepted no earlier than T+4.
REQ-027 SHALL: a read accepted in T-1 still delivers o_rd_valid in T+1 even if an accumulate is accepted in T.

Reset
REQ-028 SHALL: on i_rst: FSM=IDLE, o_req_ready=1, o_rd_valid=0, o_rd=0, o_rd_bank=0, o_err=0, read pipeline cleared.
REQ-029 SHALL: reset mid-accumulate drops the pending write-back; memory contents never altered by reset.

Configuration
REQ-030 SHALL: macro GLB_ACC_EN: when defined, accumulate per REQ-024..REQ-026.
REQ-031 SHALL: without GLB_ACC_EN, no FSM logic; i_acc ignored, write with i_acc=1 is a plain write, o_req_ready constant 1 after reset.

Verification
REQ-032 SHALL: write 0xDEADBEEF bank 2 addr 5 at T, read bank 2 addr 5 at T+1 -> o_rd_valid at T+3, o_rd=0xDEADBEEF, o_rd_bank=2.
REQ-033 SHALL: back-to-back reads banks 0,1,2,3 addr 0 (preloaded 0x10..0x13) -> four consecutive valid pulses, data 0x10..0x13, o_rd_bank 0..3 in order.
REQ-034 SHALL: (GLB_ACC_EN) entry=0xFFFFFFFF, accumulate i_wd=2 -> o_req_ready low 3 cycles, subsequent read returns 0x00000001.
REQ-035 SHALL: NUM_BANKS=3, request bank_sel=3 -> o_err pulse at T+1, no o_rd_valid, all bank contents unchanged.
REQ-036 SHALL: i_rst asserted in ACC_WAIT -> o_req_ready=1 next cycle, read of entry returns pre-accumulate value.
REQ-037 SHALL: (no GLB_ACC_EN) write i_acc=1 i_wd=7 over 5 -> read returns 7, o_req_ready never low.
